// File: rtl/ram_arbiter.sv
// Round-robin two-client controller for a 32x32 asynchronous RAM with a level-sensitive write strobe.
// Address, data and strobe are all registered and sequenced as setup / strobe / hold.
module ram_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reqA,
    input  logic          reqB,
    input  logic          weA,
    input  logic          weB,
    input  logic [AW-1:0] addrA,
    input  logic [AW-1:0] addrB,
    input  logic [DW-1:0] wdataA,
    input  logic [DW-1:0] wdataB,
    output logic          ackA,
    output logic          ackB,
    output logic [DW-1:0] rdataA,
    output logic [DW-1:0] rdataB,
    output logic          busy,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_writeOn,
    input  logic [DW-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef enum logic {
        OWNER_A,
        OWNER_B
    } owner_t;

    state_t state;
    owner_t last_owner;   // also the owner of the transaction in flight
    logic   op_we;

    logic any_req;
    logic grant_b;

    // B wins when it is alone, or on a tie when A was served last.
    assign any_req = reqA | reqB;
    assign grant_b = reqB & (~reqA | (last_owner == OWNER_A));

    // NOTE: every register here uses <= so all of them update from the same pre-edge values;
    // a blocking assignment would let later statements see this edge's new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_owner  <= OWNER_B;
            op_we       <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_writeOn <= 1'b0;
            ackA        <= 1'b0;
            ackB        <= 1'b0;
            rdataA      <= '0;
            rdataB      <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_owner  <= grant_b ? OWNER_B : OWNER_A;
                        mem_address <= grant_b ? addrB : addrA;
                        mem_data_in <= grant_b ? wdataB : wdataA;
                        op_we       <= grant_b ? weB : weA;
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    // Address and data have been stable for a full cycle before the strobe rises.
                    mem_writeOn <= op_we;
                    state       <= STROBE;
                end
                STROBE: begin
                    mem_writeOn <= 1'b0;
                    if (!op_we) begin
                        if (last_owner == OWNER_B) rdataB <= mem_data_out;
                        else                       rdataA <= mem_data_out;
                    end
                    ackA  <= (last_owner == OWNER_A);
                    ackB  <= (last_owner == OWNER_B);
                    state <= HOLD;
                end
                HOLD: begin
                    ackA  <= 1'b0;
                    ackB  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
